ai_formation: RTL
=================

AI_FORMATION -- requirements
Module: ai_formation

Interface
REQ-001 Parameter STEP_CYCLES, default 9000000; clock cycles between formation steps, i.e. 4 steps/s at 36 MHz.
REQ-002 i_clk_36MHz  input  1  sole clock; all state changes on its rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_start  input  1  debounced start; load a new wave.
REQ-005 i_enable  input  1  1 = formation marches; 0 = step timer frozen.
REQ-006 i_bullet_active  input  1  player bullet in flight.
REQ-007 i_bullet_x  input  5  bullet column, 0..31.
REQ-008 i_bullet_y  input  4  bullet row, 0..15 (0 = top).
REQ-009 o_hit  output  1  one-cycle pulse; bullet struck a live alien; feeds the player's hit input.
REQ-010 o_alive  output  24  alive bitmap; bit index = row*8 + col.
REQ-011 o_form_x  output  5  formation left column.
REQ-012 o_form_y  output  4  formation top row.
REQ-013 o_invaded  output  1  level; formation reached the ship zone.
REQ-014 o_cleared  output  1  level; all aliens destroyed.

Function
REQ-015 The grid SHALL be 3 rows x 8 columns; alien (r,c) occupies cell (form_x+2c, form_y+r), so the formation spans 15 columns.
REQ-016 The FSM SHALL have states IDLE, RIGHT, LEFT, INVADED, CLEARED.
REQ-017 When i_start=1 in any state, the next cycle SHALL hold: o_alive=24'hFFFFFF, form_x=0, form_y=1, step counter=0, state=RIGHT, no hit latch.
REQ-018 In RIGHT/LEFT with i_enable=1, the step counter SHALL increment each cycle; at STEP_CYCLES-1 it SHALL wrap to 0 and issue one step tick.
REQ-019 In RIGHT/LEFT with i_enable=0, the step counter SHALL hold its value.
REQ-020 On a RIGHT step tick: if form_x<17 then form_x+1; if form_x==17 then form_y+1, x unchanged, state LEFT.
REQ-021 On a LEFT step tick: if form_x>0 then form_x-1; if form_x==0 then form_y+1, x unchanged, state RIGHT.
REQ-022 A step-down that makes form_y==12 (bottom row 14) SHALL enter INVADED and assert o_invaded; position freezes.
REQ-023 Hit condition: state RIGHT/LEFT, i_bullet_active=1, hit latch clear, d=i_bullet_x-form_x with 0<=d<=14 and d even, row=i_bullet_y-form_y in 0..2, and o_alive[row*8+d/2]=1.
REQ-024 On the hit condition, o_hit SHALL be 1 the next cycle for exactly one cycle.
REQ-025 On the hit condition, that o_alive bit SHALL clear on the same edge that raises o_hit, and the hit latch SHALL set.
REQ-026 The hit latch SHALL clear when i_bullet_active=0, so each bullet produces at most one hit.
REQ-027 Bullet coordinates left of form_x, beyond d=14, on odd d, or outside the 3 rows SHALL never hit.
REQ-028 Hit and step tick on the same cycle: the hit SHALL be evaluated against pre-step form_x/form_y, and both updates SHALL apply.
REQ-029 When o_alive becomes 0, the next state SHALL be CLEARED with o_cleared=1; that takes priority over an INVADED transition on the same cycle.
REQ-030 IDLE, INVADED and CLEARED SHALL hold all outputs static, with o_hit=0, until i_start.
REQ-031 o_invaded and o_cleared SHALL be 1 only in their own states.

Reset
REQ-032 i_reset=1 SHALL immediately force state IDLE, o_alive=0, form_x=0, form_y=0, step counter=0, hit latch=0, and o_hit=o_invaded=o_cleared=0, independent of the clock.
REQ-033 Reset asserted mid-march or mid-hit SHALL discard the pending hit pulse; after release the block SHALL stay in IDLE until i_start.

Verification (STEP_CYCLES=4 for sim)
REQ-034 Reset, then pulse i_start -> o_alive=FFFFFF, (x,y)=(0,1), o_hit=0.
REQ-035 After start, i_enable=1 for 68 cycles -> x=17; 4 more cycles -> y=2, state LEFT; i_enable=0 for 20 cycles -> position unchanged.
REQ-036 After start, bullet (6,2) active for 10 cycles -> single o_hit pulse, bit 11 cleared; bullet (7,2) -> no hit.
REQ-037 Bullet at an alien cell coinciding with a step tick -> hit on pre-step cell, position still steps.
REQ-038 Clear all 24 aliens -> o_cleared=1 after the last hit, o_hit pulses counted =24; march until y=12 in a second wave -> o_invaded=1.
REQ-039 Assert i_reset asynchronously between clock edges mid-march -> outputs zero before the next edge; i_start restarts at (0,1).

Source files
------------

// File: rtl/ai_formation_if.sv
// Signal bundle between the alien formation block and its game logic:
// start/march control, player bullet position, and formation status.
interface ai_formation_if;
   logic        i_start;
   logic        i_enable;
   logic        i_bullet_active;
   logic [4:0]  i_bullet_x;
   logic [3:0]  i_bullet_y;
   logic        o_hit;
   logic [23:0] o_alive;
   logic [4:0]  o_form_x;
   logic [3:0]  o_form_y;
   logic        o_invaded;
   logic        o_cleared;

   modport master (
      output i_start, i_enable, i_bullet_active, i_bullet_x, i_bullet_y,
      input  o_hit, o_alive, o_form_x, o_form_y, o_invaded, o_cleared
   );

   modport slave (
      input  i_start, i_enable, i_bullet_active, i_bullet_x, i_bullet_y,
      output o_hit, o_alive, o_form_x, o_form_y, o_invaded, o_cleared
   );
endinterface

// File: rtl/ai_formation.sv
// 3x8 alien formation. It marches right and left, drops one row at each
// edge, and detects collisions with the player's bullet.
module ai_formation #(
   parameter int STEP_CYCLES = 9000000
) (
   input logic           i_clk_36MHz,
   input logic           i_reset,
   ai_formation_if.slave bus
);

   localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, RIGHT, LEFT, INVADED, CLEARED} state_t;

   state_t           state_q, state_d;
   logic [23:0]      alive_q, alive_d;
   logic [4:0]       form_x_q, form_x_d;
   logic [3:0]       form_y_q, form_y_d;
   logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic             hit_latch_q, hit_latch_d;
   logic             hit_q, hit_d;

   logic             marching;
   logic             step_tick;
   logic [5:0]       dx;
   logic [4:0]       dy;
   logic             col_ok, row_ok, target_alive, hit_cond;
   logic [4:0]       hit_idx;

   // Aliens sit on every other column, so the offset must be even and within 0..14.
   always_comb begin
      marching     = (state_q == RIGHT) || (state_q == LEFT);
      dx           = {1'b0, bus.i_bullet_x} - {1'b0, form_x_q};
      dy           = {1'b0, bus.i_bullet_y} - {1'b0, form_y_q};
      col_ok       = !dx[5] && (dx[4:0] <= 5'd14) && !dx[0];
      row_ok       = !dy[4] && (dy[3:0] <= 4'd2);
      hit_idx      = {dy[1:0], dx[3:1]};
      target_alive = row_ok ? alive_q[hit_idx] : 1'b0;
      hit_cond     = marching && bus.i_bullet_active && !hit_latch_q &&
                     col_ok && row_ok && target_alive;
      step_tick    = marching && bus.i_enable && (step_cnt_q == CNT_MAX);
   end

   always_comb begin
      state_d     = state_q;
      alive_d     = alive_q;
      form_x_d    = form_x_q;
      form_y_d    = form_y_q;
      step_cnt_d  = step_cnt_q;
      hit_latch_d = hit_latch_q;
      hit_d       = 1'b0;

      if (bus.i_start) begin
         state_d     = RIGHT;
         alive_d     = 24'hFFFFFF;
         form_x_d    = 5'd0;
         form_y_d    = 4'd1;
         step_cnt_d  = '0;
         hit_latch_d = 1'b0;
      end else if (marching) begin
         if (!bus.i_bullet_active) begin
            hit_latch_d = 1'b0;
         end
         if (hit_cond) begin
            alive_d[hit_idx] = 1'b0;
            hit_d            = 1'b1;
            hit_latch_d      = 1'b1;
         end

         if (bus.i_enable) begin
            step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
         end

         // Hit detection above uses the pre-step position; the move applies on the same edge.
         if (step_tick) begin
            if (state_q == RIGHT) begin
               if (form_x_q < 5'd17) begin
                  form_x_d = form_x_q + 5'd1;
               end else begin
                  form_y_d = form_y_q + 4'd1;
                  state_d  = LEFT;
               end
            end else begin
               if (form_x_q > 5'd0) begin
                  form_x_d = form_x_q - 5'd1;
               end else begin
                  form_y_d = form_y_q + 4'd1;
                  state_d  = RIGHT;
               end
            end
            if (form_y_d == 4'd12) begin
               state_d = INVADED;
            end
         end

         if (alive_d == 24'd0) begin
            state_d = CLEARED;
         end
      end
   end

   always_ff @(posedge i_clk_36MHz or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= IDLE;
         alive_q     <= 24'd0;
         form_x_q    <= 5'd0;
         form_y_q    <= 4'd0;
         step_cnt_q  <= '0;
         hit_latch_q <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         alive_q     <= alive_d;
         form_x_q    <= form_x_d;
         form_y_q    <= form_y_d;
         step_cnt_q  <= step_cnt_d;
         hit_latch_q <= hit_latch_d;
         hit_q       <= hit_d;
      end
   end

   assign bus.o_hit     = hit_q;
   assign bus.o_alive   = alive_q;
   assign bus.o_form_x  = form_x_q;
   assign bus.o_form_y  = form_y_q;
   assign bus.o_invaded = (state_q == INVADED);
   assign bus.o_cleared = (state_q == CLEARED);

endmodule
